mem_bus_controller: RTL and testbench
=====================================

Name: mem_bus_controller

Overview:
- Parametrised successor to the single-cycle combinational memory decoder.
- Adds a registered req/ready handshake, parametrised address map and data width, per-region programmable wait states, and an error response for unmapped accesses.
- Sits between the CPU core and the ROM / I/O controller / RAM instances, and drives their selects and write strobe.

Parameters:
- DW, 32, data width.
- AW, 16, address width.
- ROM_BASE, 16'h0000, ROM base; aligned to 2^ROM_AW.
- ROM_AW, 5, log2 of ROM size in words.
- IO_BASE, 16'h0020, I/O base; aligned to 2^IO_AW.
- IO_AW, 5, log2 of I/O size.
- RAM_BASE, 16'h0800, RAM base; aligned to 2^RAM_AW.
- RAM_AW, 11, log2 of RAM size.
- ROM_WS, 0, ROM wait states (0..15).
- IO_WS, 1, I/O wait states.
- RAM_WS, 2, RAM wait states.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  CPU request; level, held until ready.
- we  in  1  CPU write enable; qualified by req.
- address  in  AW  CPU word address.
- data_in  in  DW  CPU write data.
- data_out  out  DW  registered read data; valid when ready=1.
- ready  out  1  one-cycle completion pulse.
- error  out  1  access error; valid when ready=1.
- sel_rom, sel_io, sel_ram  out  1 each  one-hot device selects.
- dev_addr  out  RAM_AW  latched offset within the selected region; zero-extended for ROM and I/O.
- dev_we  out  1  device write strobe.
- dev_wdata  out  DW  latched write data.
- rom_rdata, io_rdata, ram_rdata  in  DW each  device read data.

Behaviour:
- Reset: state=IDLE; data_out=0; ready=0; error=0; all sel=0; dev_we=0; dev_addr=0; dev_wdata=0. Reset mid-transaction abandons the transaction; no ready is issued.
- Decode: compare upper address bits against the base; lower bits form the offset. Priority ROM > IO > RAM if parameters overlap. No match = unmapped.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, req=1:
  - Latch address offset, we and data_in.
  - Mapped: load wait counter with the region's WS, go to ACCESS.
  - Unmapped: data_out=0, error=1, go to RESP.
- IDLE, req=0: stay in IDLE.
- ACCESS:
  - Drive the region's sel for the whole state.
  - Counter != 0: decrement, stay in ACCESS.
  - Counter == 0: assert dev_we for this single cycle only, and only if a write. On reads, capture the selected rdata into data_out. error=0. Go to RESP.
- RESP: ready=1 for exactly one cycle; all sel=0; then go to IDLE.
- Latency (req sampled high in IDLE at cycle 0):
  - ACCESS occupies cycles 1..WS+1.
  - ready in cycle WS+2.
  - Unmapped: ready in cycle 1.
- Handshake rules:
  - The requester may change address/data only after ready.
  - If req is still high in the cycle after ready, that is a new transaction. Back-to-back throughput is one access per WS+3 cycles.
  - A req deasserted mid-transaction is ignored; the transaction completes.
- data_out holds its value between transactions; write transactions leave data_out unchanged.
- Width rules: DW, AW, WS all parametrised; the wait counter is 4 bits.

Optional Feature:
- Macro: ROM_WRITE_PROTECT_EN.
- Defined: a write decoded to ROM goes IDLE->RESP directly with error=1, never asserts sel_rom or dev_we, and leaves data_out unchanged.
- Undefined: ROM writes run a normal ACCESS, with dev_we pulsed alongside sel_rom. The ROM ignores the write; error=0.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req=1 -> ready=0, all sel=0, data_out=0. After release, a ROM read of 0x0003 with rom_rdata=32'hDEADBEEF -> sel_rom in cycle 1, ready and data_out=DEADBEEF in cycle 2.
- RAM write: address 0x0805, data 32'h12345678 -> sel_ram in cycles 1-3, dev_we=1 only in cycle 3, dev_addr=11'h005, ready in cycle 4, error=0.
- I/O read: address 0x0021, io_rdata=32'h0000000A -> sel_io in cycles 1-2, ready in cycle 3 with data_out=0000000A. Back-to-back second read with req held high restarts the FSM in the cycle after ready.
- Unmapped read of 0x0400 -> no sel asserted, ready=1 and error=1 in cycle 1, data_out=0.
- Reset asserted in cycle 2 of a RAM read -> no ready, FSM in IDLE; a following ROM read completes normally.
- ROM write to 0x0001 -> with ROM_WRITE_PROTECT_EN: error=1 in cycle 1, sel_rom never high. Without it: dev_we and sel_rom high in cycle 1, error=0 at ready.

Source files
------------

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: registered req/ready memory bus controller.
// Decodes a CPU word address into ROM / I/O / RAM regions, applies
// per-region wait states, drives the device selects, write strobe and latched
// offset/write data, and returns registered read data with an error flag.
//
// Handshake: the CPU raises req and holds address/we/data_in stable until it
// sees ready. ready is a one-cycle pulse; data_out and error are valid in that
// cycle. A req still high in the cycle after ready starts a new transaction.
// Dropping req before ready does not cancel the transaction in flight.
//
// Optional feature (macro ROM_WRITE_PROTECT_EN): when defined, writes decoded
// to ROM are rejected with error=1 and never reach the device.
//
// fsm_state exposes the controller state: 0 = IDLE, 1 = ACCESS, 2 = RESP.
module mem_bus_controller #(
  parameter int              DW       = 32,
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   ROM_BASE = 'h0000,
  parameter int              ROM_AW   = 5,
  parameter logic [AW-1:0]   IO_BASE  = 'h0020,
  parameter int              IO_AW    = 5,
  parameter logic [AW-1:0]   RAM_BASE = 'h0800,
  parameter int              RAM_AW   = 11,
  parameter int              ROM_WS   = 0,
  parameter int              IO_WS    = 1,
  parameter int              RAM_WS   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [AW-1:0]     address,
  input  logic [DW-1:0]     data_in,
  output logic [DW-1:0]     data_out,
  output logic              ready,
  output logic              error,
  output logic              sel_rom,
  output logic              sel_io,
  output logic              sel_ram,
  output logic [RAM_AW-1:0] dev_addr,
  output logic              dev_we,
  output logic [DW-1:0]     dev_wdata,
  input  logic [DW-1:0]     rom_rdata,
  input  logic [DW-1:0]     io_rdata,
  input  logic [DW-1:0]     ram_rdata,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_ROM  = 2'd1,
    REG_IO   = 2'd2,
    REG_RAM  = 2'd3
  } region_t;

  // Masks selecting the base-compare bits of each region; the complement
  // (truncated to the device address width) selects the offset bits.
  localparam logic [AW-1:0] ROM_MASK = {AW{1'b1}} << ROM_AW;
  localparam logic [AW-1:0] IO_MASK  = {AW{1'b1}} << IO_AW;
  localparam logic [AW-1:0] RAM_MASK = {AW{1'b1}} << RAM_AW;
  localparam logic [AW-1:0] ROM_OFF_FULL = ~ROM_MASK;
  localparam logic [AW-1:0] IO_OFF_FULL  = ~IO_MASK;
  localparam logic [AW-1:0] RAM_OFF_FULL = ~RAM_MASK;
  localparam logic [RAM_AW-1:0] ROM_OFF = ROM_OFF_FULL[RAM_AW-1:0];
  localparam logic [RAM_AW-1:0] IO_OFF  = IO_OFF_FULL[RAM_AW-1:0];
  localparam logic [RAM_AW-1:0] RAM_OFF = RAM_OFF_FULL[RAM_AW-1:0];

  state_t            state, state_d;
  region_t           region_q, dec_region;
  logic              we_q;
  logic [3:0]        cnt;
  logic [3:0]        dec_ws;
  logic [RAM_AW-1:0] dec_off;
  logic              hit_rom, hit_io, hit_ram;
  logic              wp_block;
  logic [DW-1:0]     rdata_mux;

  assign hit_rom = ((address ^ ROM_BASE) & ROM_MASK) == '0;
  assign hit_io  = ((address ^ IO_BASE)  & IO_MASK)  == '0;
  assign hit_ram = ((address ^ RAM_BASE) & RAM_MASK) == '0;

  // Priority decode of the incoming address: ROM over I/O over RAM.
  always_comb begin
    dec_region = REG_NONE;
    dec_off    = '0;
    dec_ws     = '0;
    if (hit_rom) begin
      dec_region = REG_ROM;
      dec_off    = address[RAM_AW-1:0] & ROM_OFF;
      dec_ws     = 4'(ROM_WS);
    end else if (hit_io) begin
      dec_region = REG_IO;
      dec_off    = address[RAM_AW-1:0] & IO_OFF;
      dec_ws     = 4'(IO_WS);
    end else if (hit_ram) begin
      dec_region = REG_RAM;
      dec_off    = address[RAM_AW-1:0] & RAM_OFF;
      dec_ws     = 4'(RAM_WS);
    end
  end

`ifdef ROM_WRITE_PROTECT_EN
  assign wp_block = (dec_region == REG_ROM) && we;
`else
  assign wp_block = 1'b0;
`endif

  // Read data of the region latched for the current transaction.
  always_comb begin
    rdata_mux = '0;
    case (region_q)
      REG_ROM: rdata_mux = rom_rdata;
      REG_IO:  rdata_mux = io_rdata;
      REG_RAM: rdata_mux = ram_rdata;
      default: rdata_mux = '0;
    endcase
  end

  // Next-state logic plus the state-decoded selects, strobe and ready.
  always_comb begin
    state_d = state;
    sel_rom = 1'b0;
    sel_io  = 1'b0;
    sel_ram = 1'b0;
    dev_we  = 1'b0;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (dec_region == REG_NONE || wp_block) state_d = RESP;
          else                                    state_d = ACCESS;
        end
      end
      ACCESS: begin
        sel_rom = (region_q == REG_ROM);
        sel_io  = (region_q == REG_IO);
        sel_ram = (region_q == REG_RAM);
        if (cnt == 4'd0) begin
          dev_we  = we_q;
          state_d = RESP;
        end
      end
      RESP: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Transaction latches, wait counter and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      region_q  <= REG_NONE;
      we_q      <= 1'b0;
      cnt       <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      data_out  <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            region_q  <= dec_region;
            we_q      <= we;
            cnt       <= dec_ws;
            dev_addr  <= dec_off;
            dev_wdata <= data_in;
            if (dec_region == REG_NONE) begin
              data_out <= '0;
              error    <= 1'b1;
            end else if (wp_block) begin
              error <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            error <= 1'b0;
            if (!we_q) data_out <= rdata_mux;
          end
        end
        default: ;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Testbench for mem_bus_controller: directed vector table, hand-written
// reset/corner sequences, and randomized transactions against an
// address-range reference model. Default parameters are assumed.
module tb_mem_bus_controller;

  localparam int ROM_LO = 0;
  localparam int ROM_SZ = 32;
  localparam int IO_LO  = 32;
  localparam int IO_SZ  = 32;
  localparam int RAM_LO = 2048;
  localparam int RAM_SZ = 2048;

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        error;
  logic        sel_rom, sel_io, sel_ram;
  logic [10:0] dev_addr;
  logic        dev_we;
  logic [31:0] dev_wdata;
  logic [31:0] rom_rdata, io_rdata, ram_rdata;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_dout;
  logic        at_ready;

  mem_bus_controller dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .ready     (ready),
    .error     (error),
    .sel_rom   (sel_rom),
    .sel_io    (sel_io),
    .sel_ram   (sel_ram),
    .dev_addr  (dev_addr),
    .dev_we    (dev_we),
    .dev_wdata (dev_wdata),
    .rom_rdata (rom_rdata),
    .io_rdata  (io_rdata),
    .ram_rdata (ram_rdata),
    .fsm_state (fsm_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    logic        w;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        b2b;
    logic [2:0]  sel;    // {rom, io, ram}
    int          rdy;    // cycle in which ready is expected
    logic        err;
    logic [31:0] dout;
    logic [10:0] off;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: region by address range, latency from wait states.
  task automatic model(input logic [15:0] a, input logic w,
                       output logic [2:0] sel, output int rdy,
                       output logic err, output logic [10:0] off);
    int ai;
    int ws;
    ai  = int'(a);
    sel = 3'b000;
    off = '0;
    ws  = 0;
    if (ai >= ROM_LO && ai < ROM_LO + ROM_SZ) begin
      sel = 3'b100; ws = 0; off = 11'(ai - ROM_LO);
    end else if (ai >= IO_LO && ai < IO_LO + IO_SZ) begin
      sel = 3'b010; ws = 1; off = 11'(ai - IO_LO);
    end else if (ai >= RAM_LO && ai < RAM_LO + RAM_SZ) begin
      sel = 3'b001; ws = 2; off = 11'(ai - RAM_LO);
    end
`ifdef ROM_WRITE_PROTECT_EN
    if (sel == 3'b100 && w) sel = 3'b000;
`endif
    if (sel == 3'b000) begin
      rdy = 1; err = 1'b1;
    end else begin
      rdy = ws + 2; err = 1'b0;
    end
  endtask

  // Drive req low for n cycles and confirm the controller stays quiet.
  task automatic idle_cycles(input int n);
    req = 1'b0;
    at_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_ready", 32'(ready), 32'd0);
      chk("idle_sel", 32'({sel_rom, sel_io, sel_ram}), 32'd0);
      chk("idle_state", 32'(fsm_state), 32'd0);
      chk("idle_dout_hold", data_out, model_dout);
    end
  endtask

  // Driver + per-cycle monitor for one transaction.
  task automatic run_txn(input logic [15:0] a, input logic w, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [2:0] esel, input int erdy,
                         input logic eerr, input logic [31:0] edout, input logic [10:0] eoff,
                         input logic drop);
    logic [31:0] prev;
    logic [31:0] exp_d;
    prev      = model_dout;
    req       = 1'b1;
    address   = a;
    we        = w;
    data_in   = wd;
    rom_rdata = esel[2] ? rd : ~rd;
    io_rdata  = esel[1] ? rd : rd ^ 32'h5A5A_5A5A;
    ram_rdata = esel[0] ? rd : rd ^ 32'h0F0F_F0F0;
    if (at_ready) begin
      step();
      chk("b2b_gap_ready", 32'(ready), 32'd0);
      chk("b2b_gap_state", 32'(fsm_state), 32'd0);
    end
    exp_q.push_back(edout);
    for (int c = 1; c <= erdy; c++) begin
      step();
      if (c == 1 && drop) req = 1'b0;
      chk("sel", 32'({sel_rom, sel_io, sel_ram}), 32'((c < erdy) ? esel : 3'b000));
      chk("dev_we", 32'(dev_we), 32'(w && esel != 3'b000 && c == erdy - 1));
      chk("ready", 32'(ready), 32'(c == erdy));
      if (c < erdy) begin
        chk("dout_hold", data_out, prev);
        if (esel != 3'b000) begin
          chk("dev_addr", 32'(dev_addr), 32'(eoff));
          chk("dev_wdata", dev_wdata, wd);
        end
      end else begin
        chk("error", 32'(error), 32'(eerr));
        exp_d = exp_q.pop_front();
        chk("data_out", data_out, exp_d);
      end
    end
    model_dout = edout;
    at_ready   = 1'b1;
  endtask

  initial begin
    logic [2:0]  rsel;
    int          rrdy;
    logic        rerr;
    logic [10:0] roff;
    logic [15:0] ra;
    logic        rw;
    logic [31:0] rwd, rrd, rdout;

    vecs[0]  = '{16'h0003, 1'b0, 32'h0,         32'hDEADBEEF, 1'b0, 3'b100, 2, 1'b0, 32'hDEADBEEF, 11'h003};
    vecs[1]  = '{16'h0805, 1'b1, 32'h12345678,  32'h11111111, 1'b0, 3'b001, 4, 1'b0, 32'hDEADBEEF, 11'h005};
    vecs[2]  = '{16'h0021, 1'b0, 32'h0,         32'h0000000A, 1'b0, 3'b010, 3, 1'b0, 32'h0000000A, 11'h001};
    vecs[3]  = '{16'h003F, 1'b0, 32'h0,         32'h55AA55AA, 1'b1, 3'b010, 3, 1'b0, 32'h55AA55AA, 11'h01F};
    vecs[4]  = '{16'h0400, 1'b0, 32'h0,         32'h22222222, 1'b0, 3'b000, 1, 1'b1, 32'h00000000, 11'h000};
    vecs[5]  = '{16'h0FFF, 1'b0, 32'h0,         32'hCAFEF00D, 1'b0, 3'b001, 4, 1'b0, 32'hCAFEF00D, 11'h7FF};
    vecs[6]  = '{16'h0800, 1'b1, 32'h0BADC0DE,  32'h33333333, 1'b1, 3'b001, 4, 1'b0, 32'hCAFEF00D, 11'h000};
    vecs[7]  = '{16'h1000, 1'b0, 32'h0,         32'h44444444, 1'b0, 3'b000, 1, 1'b1, 32'h00000000, 11'h000};
    vecs[8]  = '{16'h0040, 1'b0, 32'h0,         32'h66666666, 1'b0, 3'b000, 1, 1'b1, 32'h00000000, 11'h000};
    vecs[9]  = '{16'h001F, 1'b0, 32'h0,         32'h13579BDF, 1'b0, 3'b100, 2, 1'b0, 32'h13579BDF, 11'h01F};
`ifdef ROM_WRITE_PROTECT_EN
    vecs[10] = '{16'h0001, 1'b1, 32'hFFFF0000,  32'h77777777, 1'b0, 3'b000, 1, 1'b1, 32'h13579BDF, 11'h001};
`else
    vecs[10] = '{16'h0001, 1'b1, 32'hFFFF0000,  32'h77777777, 1'b0, 3'b100, 2, 1'b0, 32'h13579BDF, 11'h001};
`endif
    vecs[11] = '{16'h0020, 1'b1, 32'h00000077,  32'h88888888, 1'b0, 3'b010, 3, 1'b0, 32'h13579BDF, 11'h000};
    vecs[12] = '{16'hFFFF, 1'b0, 32'h0,         32'h99999999, 1'b1, 3'b000, 1, 1'b1, 32'h00000000, 11'h000};

    // Reset with req held high.
    reset = 1'b1; req = 1'b1; we = 1'b0; address = 16'h0003; data_in = 32'hA5A5A5A5;
    rom_rdata = '0; io_rdata = '0; ram_rdata = '0;
    at_ready = 1'b0; model_dout = '0;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_sel", 32'({sel_rom, sel_io, sel_ram}), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_dev_we", 32'(dev_we), 32'd0);
    chk("rst_dev_addr", 32'(dev_addr), 32'd0);
    chk("rst_dev_wdata", dev_wdata, 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      if (i > 0 && !vecs[i].b2b) idle_cycles(2);
      run_txn(vecs[i].addr, vecs[i].w, vecs[i].wdata, vecs[i].rd, vecs[i].sel,
              vecs[i].rdy, vecs[i].err, vecs[i].dout, vecs[i].off, 1'b0);
    end

    // Reset in cycle 2 of a RAM read abandons it.
    idle_cycles(1);
    req = 1'b1; we = 1'b0; address = 16'h0900; ram_rdata = 32'hBADBAD00;
    step();
    req = 1'b0;
    chk("mid_rst_sel_c1", 32'({sel_rom, sel_io, sel_ram}), 32'b001);
    step();
    chk("mid_rst_sel_c2", 32'({sel_rom, sel_io, sel_ram}), 32'b001);
    reset = 1'b1;
    step();
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_state", 32'(fsm_state), 32'd0);
    chk("mid_rst_dout", data_out, 32'd0);
    reset = 1'b0;
    model_dout = '0;
    idle_cycles(3);
    run_txn(16'h0007, 1'b0, 32'h0, 32'h0BEEF123, 3'b100, 2, 1'b0, 32'h0BEEF123, 11'h007, 1'b0);

    // Mid-transaction req drop is ignored.
    idle_cycles(1);
    run_txn(16'h0A10, 1'b0, 32'h0, 32'h7E57DA7A, 3'b001, 4, 1'b0, 32'h7E57DA7A, 11'h210, 1'b1);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0:       ra = 16'(ROM_LO + $urandom_range(0, ROM_SZ - 1));
        1:       ra = 16'(IO_LO + $urandom_range(0, IO_SZ - 1));
        2:       ra = 16'(RAM_LO + $urandom_range(0, RAM_SZ - 1));
        default: ra = 16'($urandom_range(0, 65535));
      endcase
      rw  = 1'($urandom_range(0, 1));
      rwd = $urandom;
      rrd = $urandom;
      model(ra, rw, rsel, rrdy, rerr, roff);
      if (rsel == 3'b000 && rerr && !rw) rdout = 32'd0;
      else if (rsel == 3'b000 && (int'(ra) >= ROM_LO + ROM_SZ || int'(ra) < ROM_LO)) rdout = 32'd0;
      else if (rw) rdout = model_dout;
      else rdout = rrd;
      if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 2));
      run_txn(ra, rw, rwd, rrd, rsel, rrdy, rerr, rdout, roff, 1'($urandom_range(0, 3) == 0));
    end

    idle_cycles(2);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
